mem_responder: RTL
==================

Name: mem_responder

Overview:
Memory-side responder to the multicycle control unit's MemRead/MemWrite strobes. It accepts one access per strobe assertion, inserts a programmable number of wait states, and then performs a word read or write on an internal synchronous RAM. It returns ReadData with a one-cycle MemReady pulse, so the control FSM can stall memory states (instruction fetch, LWI, SWI) until the access completes.

Parameters:
ADDR_W, 8, address width in words
DATA_W, 16, data word width
DEPTH, 256, number of RAM words (2**ADDR_W)
WAIT_CYC, 2, wait states between accept and access, legal range 0..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears the block
MemRead  in  1  read request strobe, level, from control
MemWrite  in  1  write request strobe, level, from control
Addr  in  ADDR_W  word address, sampled at accept
WriteData  in  DATA_W  store data, sampled at accept
ReadData  out  DATA_W  read result, held until the next read completes
MemReady  out  1  one-cycle pulse when the access completes
Busy  out  1  high from the cycle after accept until MemReady, inclusive
Err  out  1  one-cycle pulse when MemRead and MemWrite are both high in IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, wait counter=0, ReadData=0, MemReady=0, Busy=0, Err=0, latched addr/data/op=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE:
  - Exactly one of MemRead/MemWrite high: latch Addr, WriteData and op; load counter=WAIT_CYC. Go to WAIT if WAIT_CYC>0, otherwise go to ACCESS.
  - Both strobes high: Err=1 for one cycle, no access, go to HOLD.
  - Neither high: stay in IDLE.
- WAIT: decrement counter each cycle. When the counter reaches 1, go to ACCESS on the next edge. Total cycles spent in WAIT = WAIT_CYC.
- ACCESS, one cycle:
  - Read: ReadData <= RAM[latched addr].
  - Write: RAM[latched addr] <= latched data; ReadData unchanged.
  - MemReady=1 in the cycle after ACCESS, registered. Then go to HOLD.
- Latency: with the strobe sampled high at edge N, MemReady is high in cycle N+WAIT_CYC+2 (WAIT_CYC=2 gives 4 cycles). ReadData is valid in the same cycle as MemReady.
- HOLD: wait until MemRead and MemWrite are both low, then go to IDLE. A strobe held high therefore causes exactly one access. Back-to-back accesses need at least one low cycle between strobes.
- Addr, WriteData and strobe changes while Busy are ignored. The latched values are used.
- Busy=1 in WAIT, ACCESS and the MemReady cycle. Busy=0 in IDLE and HOLD once MemReady has fallen.
- Reset mid-access: the access is aborted. A write that has not reached ACCESS does not modify the RAM. No MemReady is issued.
- Address wrap: Addr is ADDR_W bits, so there are no out-of-range accesses.

Decomposition:
- Package mem_responder_pkg holds:
  - State encoding constants: IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, HOLD=2'b11.
  - Op encoding: OP_RD=1'b0, OP_WR=1'b1.
- One sub-module, mem_array: single-port synchronous RAM (DEPTH x DATA_W) with we, addr, din, registered dout. Its read latency is absorbed by the ACCESS cycle.
- The FSM, counter and handshake registers stay in mem_responder.

Test Plan:
- Reset hold: reset=0 for 3 cycles with MemRead=1 -> ReadData=0, MemReady=0, Busy=0, Err=0, no access.
- Write then read, WAIT_CYC=2: MemWrite pulse with Addr=8'h10, WriteData=16'hBEEF -> MemReady 4 cycles after accept. Then MemRead with Addr=8'h10 -> ReadData=16'hBEEF with MemReady 4 cycles after accept.
- Held strobe: MemRead held high for 20 cycles at Addr=8'h10 -> exactly one MemReady pulse. Drop the strobe for 1 cycle, reassert -> a second pulse.
- Conflict: MemRead=MemWrite=1 in IDLE with Addr=8'h10, WriteData=16'h1234 -> Err pulse for 1 cycle, no MemReady. A subsequent read returns 16'hBEEF.
- Reset mid-write: MemWrite with Addr=8'h20, WriteData=16'hAAAA, then reset=0 one cycle after accept -> no MemReady. A read of 8'h20 returns the prior contents (16'h0000 after a preload of 0).
- WAIT_CYC=0 build: MemRead at Addr=8'h10 -> MemReady 2 cycles after accept; Addr changed during Busy does not affect ReadData.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states and access opcodes.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    HOLD   = 2'b11
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM with a registered read port; contents are never reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one access per strobe assertion, WAIT_CYC wait states, then a RAM
// read/write with a registered MemReady pulse; strobes must drop before the next access.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              Err
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYC);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_dout;

  // In IDLE the RAM is addressed straight from the port so that, with no wait states,
  // the registered read data is already valid during the ACCESS cycle.
  assign ram_addr = (state_q == IDLE) ? Addr : addr_q;
  assign ram_we   = (state_q == ACCESS) && (op_q == OP_WR) && reset;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead && MemWrite) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else if (MemRead || MemWrite) begin
          addr_d  = Addr;
          data_d  = WriteData;
          op_d    = MemWrite ? OP_WR : OP_RD;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CYC == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        if (op_q == OP_RD) rdata_d = ram_dout;
        ready_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!MemRead && !MemWrite) state_d = IDLE;
      end
    endcase
    // Busy covers WAIT, ACCESS and the MemReady cycle that follows ACCESS.
    busy_d = (state_d == WAIT) || (state_d == ACCESS) || (state_q == ACCESS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= OP_RD;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign Busy     = busy_q;
  assign Err      = err_q;

endmodule
